// File: rtl/lbus_pkg.sv
// rtl/lbus_pkg.sv - shared types and constants for the local register bus
// Decoder state encoding, error read-back pattern and error counter width.
package lbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lbus_dec_state_e;

  localparam logic [31:0] LBUS_ERR_DATA  = 32'hDEAD_BEEF;
  localparam int          LBUS_ERR_CNT_W = 16;

endpackage

// File: rtl/lbus_timeout_cnt.sv
// rtl/lbus_timeout_cnt.sv - access watchdog for local-bus masters
// Counts enabled cycles after a clear; expire is high while the count sits at TIMEOUT-1.
module lbus_timeout_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  assign w_expire = (r_cnt == LAST);
  assign o_expire = w_expire;

  // Holds at the terminal value so expire stays asserted until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lbus_reg_decoder.sv
// rtl/lbus_reg_decoder.sv - routes single-outstanding register requests to slave windows
// Address-window decode, per-access watchdog, registered ack/err/rdata and a saturating error count.
module lbus_reg_decoder
  import lbus_pkg::*;
#(
  parameter int LBUS_AW = 18,
  parameter int N_SLV   = 4,
  parameter int SLV_AW  = 12,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      axi_reg_req,
  input  logic                      axi_reg_rw,
  input  logic [31:2]               axi_reg_addr,
  input  logic [31:0]               axi_reg_wdata,
  output logic [31:0]               axi_reg_rdata,
  output logic                      axi_reg_ack,
  output logic                      axi_reg_err,
  output logic [N_SLV-1:0]          slv_sel,
  output logic                      slv_rw,
  output logic [SLV_AW-1:2]         slv_addr,
  output logic [31:0]               slv_wdata,
  input  logic [N_SLV*32-1:0]       slv_rdata,
  input  logic [N_SLV-1:0]          slv_ack,
  output logic [LBUS_ERR_CNT_W-1:0] err_cnt
);

  localparam int IW = $clog2(N_SLV);

  lbus_dec_state_e           r_state;
  lbus_dec_state_e           w_state_nxt;
  logic [N_SLV-1:0]          r_sel;
  logic [N_SLV-1:0]          w_sel_nxt;
  logic                      r_rw;
  logic                      w_rw_nxt;
  logic [SLV_AW-1:2]         r_addr;
  logic [SLV_AW-1:2]         w_addr_nxt;
  logic [31:0]               r_wdata;
  logic [31:0]               w_wdata_nxt;
  logic [31:0]               r_rdata;
  logic [31:0]               w_rdata_nxt;
  logic                      r_err;
  logic                      w_err_nxt;
  logic                      r_ack;
  logic                      w_ack_nxt;
  logic [LBUS_ERR_CNT_W-1:0] r_err_cnt;

  logic [IW-1:0]             w_idx;
  logic                      w_dec_err;
  logic [N_SLV-1:0]          w_sel_dec;
  logic                      w_slv_ack;
  logic [31:0]               w_slv_rdata;
  logic                      w_tmr_clr;
  logic                      w_tmr_en;
  logic                      w_tmr_expire;

  assign w_idx     = axi_reg_addr[SLV_AW+IW-1:SLV_AW];
  assign w_dec_err = (|axi_reg_addr[31:LBUS_AW]) || (32'(w_idx) >= 32'(N_SLV));
  assign w_sel_dec = {{(N_SLV-1){1'b0}}, 1'b1} << w_idx;

  // Address bits between the slave index and LBUS_AW alias onto the same windows.
  generate
    if (LBUS_AW > SLV_AW + IW) begin : g_alias
      logic w_unused_alias;
      assign w_unused_alias = ^axi_reg_addr[LBUS_AW-1:SLV_AW+IW];
    end
  endgenerate

  // r_sel is one-hot on the selected slave, so masking ignores acks from other slaves.
  assign w_slv_ack = |(slv_ack & r_sel);

  always_comb begin
    w_slv_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (r_sel[i]) begin
        w_slv_rdata = w_slv_rdata | slv_rdata[32*i +: 32];
      end
    end
  end

  lbus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_tmr_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_rw_nxt    = r_rw;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_ack_nxt   = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_en    = 1'b0;
    case (r_state)
      IDLE: begin
        w_tmr_clr = 1'b1;
        if (axi_reg_req) begin
          if (w_dec_err) begin
            w_err_nxt   = 1'b1;
            w_rdata_nxt = LBUS_ERR_DATA;
            w_ack_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_sel_nxt   = w_sel_dec;
            w_rw_nxt    = axi_reg_rw;
            w_addr_nxt  = axi_reg_addr[SLV_AW-1:2];
            w_wdata_nxt = axi_reg_wdata;
            w_state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        w_tmr_en = 1'b1;
        // Ack is tested first so an ack on the expiry cycle still completes cleanly.
        if (w_slv_ack) begin
          if (!r_rw) begin
            w_rdata_nxt = w_slv_rdata;
          end
          w_err_nxt   = 1'b0;
          w_sel_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = DONE;
        end else if (w_tmr_expire) begin
          w_err_nxt   = 1'b1;
          w_rdata_nxt = LBUS_ERR_DATA;
          w_sel_nxt   = '0;
          w_ack_nxt   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_sel_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_ack     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_rw    <= w_rw_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      r_ack   <= w_ack_nxt;
      if (w_ack_nxt && w_err_nxt && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + LBUS_ERR_CNT_W'(1);
      end
    end
  end

  assign axi_reg_rdata = r_rdata;
  assign axi_reg_ack   = r_ack;
  assign axi_reg_err   = r_err;
  assign slv_sel       = r_sel;
  assign slv_rw        = r_rw;
  assign slv_addr      = r_addr;
  assign slv_wdata     = r_wdata;
  assign err_cnt       = r_err_cnt;

endmodule
